// File: rtl/bidir_shift_register.sv
// bidir_shift_register: N-bit bidirectional shift register with load, 1-bit and dibit shifts on falling enable.
// Dibit shifts (OP 100/101) exist only when BIDIR_SHIFTREG_PT2272_EN is defined; otherwise those codes hold.
module bidir_shift_register #(
    parameter int N = 4
) (
    input  logic         enable,
    input  logic         rst_n,
    input  logic         shift_in,
    input  logic [N-1:0] d,
    input  logic [1:0]   PT2272_BIT,
    input  logic [2:0]   OP,
    output logic [N-1:0] q,
    output logic         shift_out_right,
    output logic         shift_out_left
);
    logic [N-1:0] q_q, q_d;
`ifdef BIDIR_SHIFTREG_PT2272_EN
    // Widened concatenations keep the dibit shifts legal down to N == 2.
    logic [N+1:0] lcat, rcat;
    assign lcat = {q_q, PT2272_BIT};
    assign rcat = {PT2272_BIT, q_q};
`else
    logic pt_unused;
    assign pt_unused = ^PT2272_BIT;
`endif
    always_comb begin
        q_d = q_q;
        case (OP)
            3'b001: q_d = {q_q[N-2:0], shift_in};
            3'b010: q_d = {shift_in, q_q[N-1:1]};
            3'b011: q_d = d;
`ifdef BIDIR_SHIFTREG_PT2272_EN
            3'b100: q_d = lcat[N-1:0];
            3'b101: q_d = rcat[N+1:2];
`endif
            default: q_d = q_q;
        endcase
    end
    always_ff @(negedge enable or negedge rst_n) begin
        if (!rst_n) q_q <= '0;
        else        q_q <= q_d;
    end
    assign q               = q_q;
    assign shift_out_right = q_q[0];
    assign shift_out_left  = q_q[N-1];
endmodule

// File: tb/tb_bidir_shift_register.sv
// tb_bidir_shift_register: directed and randomized checks against an arithmetic model of the register.
module tb_bidir_shift_register;
    logic       enable = 1'b1;
    logic       rst_n = 1'b0;
    logic       shift_in = 1'b0;
    logic [3:0] d = '0;
    logic [1:0] pt = '0;
    logic [2:0] op = '0;
    logic [3:0] q;
    logic       sor, sol;
    int checks = 0;
    int failures = 0;
    int mq = 0;

    bidir_shift_register #(.N(4)) dut (
        .enable(enable), .rst_n(rst_n), .shift_in(shift_in), .d(d),
        .PT2272_BIT(pt), .OP(op), .q(q),
        .shift_out_right(sor), .shift_out_left(sol)
    );

    always #5 enable = ~enable;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [2:0] o, input logic si, input logic [3:0] dd, input logic [1:0] p);
        case (o)
            3'd1: mq = ((mq * 2) + si) % 16;
            3'd2: mq = (mq / 2) + si * 8;
            3'd3: mq = dd;
`ifdef BIDIR_SHIFTREG_PT2272_EN
            3'd4: mq = ((mq * 4) + p) % 16;
            3'd5: mq = (mq / 4) + p * 4;
`endif
            default: mq = mq;
        endcase
    endtask

    task automatic step(input string tag, input logic [2:0] o, input logic si, input logic [3:0] dd, input logic [1:0] p);
        @(posedge enable);
        op = o; shift_in = si; d = dd; pt = p;
        @(negedge enable);
        #1;
        model(o, si, dd, p);
        chk({tag, ".q"}, {28'd0, q}, mq);
        chk({tag, ".left"}, {31'd0, sol}, (mq / 8) % 2);
        chk({tag, ".right"}, {31'd0, sor}, mq % 2);
    endtask

    initial begin
        #1;
        chk("reset.q", {28'd0, q}, 0);
        @(posedge enable);
        rst_n = 1'b1;
        step("load1010", 3'd3, 0, 4'b1010, 0);
        chk("load1010.lit", {28'd0, q}, 4'b1010);
        step("r1", 3'd2, 0, 0, 0); chk("r1.lit", {28'd0, q}, 4'b0101);
        step("r2", 3'd2, 0, 0, 0); chk("r2.lit", {28'd0, q}, 4'b0010);
        step("r3", 3'd2, 0, 0, 0); chk("r3.lit", {28'd0, q}, 4'b0001);
        step("r4", 3'd2, 0, 0, 0); chk("r4.lit", {28'd0, q}, 4'b0000);
        step("load1010b", 3'd3, 0, 4'b1010, 0);
        step("l1", 3'd1, 0, 0, 0); chk("l1.lit", {28'd0, q}, 4'b0100);
        step("l2", 3'd1, 0, 0, 0); chk("l2.lit", {28'd0, q}, 4'b1000);
        step("l3", 3'd1, 0, 0, 0); chk("l3.lit", {28'd0, q}, 4'b0000);
        step("load1111", 3'd3, 0, 4'b1111, 0);
        step("l4a", 3'd1, 0, 0, 0); chk("l4a.lit", {28'd0, q}, 4'b1110);
        step("l4b", 3'd1, 0, 0, 0); chk("l4b.lit", {28'd0, q}, 4'b1100);
        step("l4c", 3'd1, 0, 0, 0); chk("l4c.lit", {28'd0, q}, 4'b1000);
        step("l4d", 3'd1, 0, 0, 0); chk("l4d.lit", {28'd0, q}, 4'b0000);
        step("sil", 3'd1, 1, 0, 0); chk("sil.lit", {28'd0, q}, 4'b0001);
        step("sir", 3'd2, 1, 0, 0); chk("sir.lit", {28'd0, q}, 4'b1000);
        step("load1111b", 3'd3, 0, 4'b1111, 0);
        step("hold000", 3'd0, 0, 4'b0000, 0); chk("hold000.lit", {28'd0, q}, 4'b1111);
        step("hold110", 3'd6, 0, 4'b0000, 0); chk("hold110.lit", {28'd0, q}, 4'b1111);
        step("hold111", 3'd7, 1, 4'b0000, 0); chk("hold111.lit", {28'd0, q}, 4'b1111);
`ifdef BIDIR_SHIFTREG_PT2272_EN
        step("dl00", 3'd4, 0, 0, 2'b00); chk("dl00.lit", {28'd0, q}, 4'b1100);
        step("dr11", 3'd5, 0, 0, 2'b11); chk("dr11.lit", {28'd0, q}, 4'b1111);
        step("dr10", 3'd5, 0, 0, 2'b10); chk("dr10.lit", {28'd0, q}, 4'b1011);
        step("dl11", 3'd4, 0, 0, 2'b11); chk("dl11.lit", {28'd0, q}, 4'b1111);
        step("dl01", 3'd4, 0, 0, 2'b01); chk("dl01.lit", {28'd0, q}, 4'b1101);
`else
        step("dl00", 3'd4, 0, 0, 2'b00); chk("dl00.lit", {28'd0, q}, 4'b1111);
        step("dr11", 3'd5, 0, 0, 2'b11); chk("dr11.lit", {28'd0, q}, 4'b1111);
        step("dr10", 3'd5, 0, 0, 2'b10); chk("dr10.lit", {28'd0, q}, 4'b1111);
        step("dl11", 3'd4, 0, 0, 2'b11); chk("dl11.lit", {28'd0, q}, 4'b1111);
        step("dl01", 3'd4, 0, 0, 2'b01); chk("dl01.lit", {28'd0, q}, 4'b1111);
`endif
        step("load1111c", 3'd3, 0, 4'b1111, 0);
        @(posedge enable);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst.q", {28'd0, q}, 0);
        chk("async_rst.left", {31'd0, sol}, 0);
        chk("async_rst.right", {31'd0, sor}, 0);
        op = 3'd3; d = 4'b1010;
        @(negedge enable);
        #1;
        chk("rst_edge.q", {28'd0, q}, 0);
        @(posedge enable);
        rst_n = 1'b1;
        @(negedge enable);
        #1;
        chk("release.q", {28'd0, q}, 4'b1010);
        mq = 4'b1010;
        for (int i = 0; i < 200; i++)
            step("rand", 3'($urandom_range(0, 7)), 1'($urandom), 4'($urandom), 2'($urandom));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
